secure_storage_initiator: RTL and testbench
===========================================

Name: secure_storage_initiator

Overview:
- Request-side controller for the 256x32 secure storage array; the only path by which client logic reads or writes storage words.
- Accepts one transaction at a time over a valid/ready request channel and checks it against a per-region permission table that is default-deny.
- Permitted transactions are driven onto the storage port. Every accepted request, permitted or denied, gets exactly one response on a valid/ready response channel.

Parameters:
- REGIONS, 4, number of equal address regions; region index = addr[7:8-log2(REGIONS)]; must be a power of two, 2..16.
- DENY_DATA, 32'hDEAD_BEEF, value returned in rsp_rdata for denied reads.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- req_valid  in  1  request valid
- req_ready  out  1  controller can accept a request
- req_write  in  1  1 = write, 0 = read
- req_addr  in  8  word address
- req_wdata  in  32  write data
- rsp_valid  out  1  response valid
- rsp_ready  in  1  response consumed
- rsp_rdata  out  32  read data (0 for writes)
- rsp_err  out  1  1 = access denied
- cfg_we  in  1  permission table write strobe
- cfg_region  in  log2(REGIONS)  region to configure
- cfg_perm  in  2  {W,R} permission bits
- cfg_lock  in  1  set lock; sticky until reset
- locked  out  1  table locked
- mem_addr  out  8  storage address
- mem_wdata  out  32  storage write data
- mem_we  out  1  storage write enable
- mem_rdata  in  32  storage read data, registered by storage (1-cycle latency)

Behaviour:
- Reset values:
  - FSM = IDLE; all perm entries = 2'b00 (no access); locked = 0.
  - req_ready = 0 during reset, 1 in IDLE after reset; rsp_valid = 0.
  - rsp_rdata = 0; rsp_err = 0; mem_addr = 0; mem_wdata = 0; mem_we = 0.
- Permission table:
  - On cfg_we && !locked, perm[cfg_region] <= cfg_perm.
  - cfg_lock sets locked, which is sticky until reset. cfg_we in the same cycle as cfg_lock still takes effect.
  - While locked, cfg_we is ignored.
  - A cfg_we in the same cycle a request is accepted takes effect after the check; the check uses the old value.
- FSM states: IDLE, WRITE, READ, CAPTURE, RESP.
- IDLE:
  - req_ready = 1. On req_valid, latch write/addr/wdata and check perm of region(addr): W bit for writes, R bit for reads.
  - Denied request -> RESP with rsp_err = 1. rsp_rdata = DENY_DATA for reads, 0 for writes. mem_we is never asserted.
  - Permitted write -> WRITE. Permitted read -> READ.
- WRITE: mem_we = 1 for exactly one cycle with mem_addr/mem_wdata = latched values; next state RESP with rsp_err = 0, rsp_rdata = 0.
- READ: mem_addr = latched addr, mem_we = 0; next state CAPTURE.
- CAPTURE: rsp_rdata <= mem_rdata; next state RESP.
- RESP:
  - rsp_valid = 1; outputs held stable until rsp_ready. Leave on rsp_valid && rsp_ready -> IDLE.
  - req_ready = 0 in every state except IDLE.
- Latency from accept edge to rsp_valid: write 2 cycles, read 3 cycles, denied 1 cycle. Throughput is one transaction per response handshake plus 1 cycle.
- mem_we is asserted only in WRITE. mem_addr holds its last value otherwise.
- Address wrap: none; the 8-bit address covers the full array, and addr 8'hFF maps to the last region.
- Reset mid-transaction: the transaction is abandoned, no response is issued, and a partially driven mem_we is deasserted asynchronously.

Optional Feature:
- Macro: SECURE_STORAGE_AUDIT_EN.
- Defined:
  - Adds outputs deny_count (16-bit, saturating at 16'hFFFF) and last_deny_addr (8-bit), both reset to 0.
  - Both update on the cycle a denied request is accepted.
- Undefined: these ports and registers are absent; all other behaviour is identical.

Test Plan:
- Read addr 8'h10 right after reset, no cfg -> rsp_err = 1, rsp_rdata = 32'hDEAD_BEEF, mem_we never 1.
- Set perm[0] = 2'b11, write 32'h1234_5678 to 8'h05, then read 8'h05 -> write rsp_err = 0; read rsp_rdata = 32'h1234_5678, rsp_valid 3 cycles after accept.
- Set perm[3] = 2'b01 (read-only), write 8'hC0 -> rsp_err = 1, mem_we stays 0; a subsequent read of 8'hC0 returns the prior contents with rsp_err = 0.
- Set cfg_lock, then cfg_we region 1 = 2'b11 -> locked = 1, perm[1] remains 2'b00, and a read of 8'h40 is denied.
- Hold rsp_ready = 0 for 5 cycles during a read response -> rsp_valid/rsp_rdata stable, req_ready = 0, a new req_valid is not accepted.
- Assert rst_n = 0 during CAPTURE -> no rsp_valid; after release, req_ready = 1, locked = 0, all perms cleared; with AUDIT_EN, 3 denials give deny_count = 3 and last_deny_addr = the third address.

Source files
------------

// File: rtl/secure_storage_initiator.sv
// Secure storage request controller: default-deny per-region permission check in front of the 256x32 array.
// Optional audit counters are compiled in with `define SECURE_STORAGE_AUDIT_EN.
//
// state   | meaning
// IDLE    | ready for a request; permission check happens on accept
// WRITE   | mem_we pulsed for one cycle with latched address/data
// READ    | latched address presented to storage
// CAPTURE | storage read data registered into rsp_rdata
// RESP    | response held until rsp_ready
module secure_storage_initiator #(
   parameter int          REGIONS   = 4,
   parameter logic [31:0] DENY_DATA = 32'hDEAD_BEEF
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       req_valid,
   output logic                       req_ready,
   input  logic                       req_write,
   input  logic [7:0]                 req_addr,
   input  logic [31:0]                req_wdata,
   output logic                       rsp_valid,
   input  logic                       rsp_ready,
   output logic [31:0]                rsp_rdata,
   output logic                       rsp_err,
   input  logic                       cfg_we,
   input  logic [$clog2(REGIONS)-1:0] cfg_region,
   input  logic [1:0]                 cfg_perm,
   input  logic                       cfg_lock,
   output logic                       locked,
   output logic [7:0]                 mem_addr,
   output logic [31:0]                mem_wdata,
   output logic                       mem_we,
   input  logic [31:0]                mem_rdata
`ifdef SECURE_STORAGE_AUDIT_EN
   ,
   output logic [15:0]                deny_count,
   output logic [7:0]                 last_deny_addr
`endif
);

   localparam int RW = $clog2(REGIONS);

   typedef enum logic [2:0] {IDLE, WRITE, READ, CAPTURE, RESP} state_t;

   state_t        state;
   state_t        state_nx;
   logic [1:0]    perm [REGIONS];
   logic [RW-1:0] req_region;
   logic          allowed;
   logic          accept;
   logic          idle_out;

   assign req_region = req_addr[7 -: RW];
   assign allowed    = req_write ? perm[req_region][1] : perm[req_region][0];
   assign accept     = req_valid && (state == IDLE);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nx;
   end

   always_comb begin
      state_nx  = state;
      idle_out  = 1'b0;
      rsp_valid = 1'b0;
      mem_we    = 1'b0;
      case (state)
         IDLE: begin
            idle_out = 1'b1;
            if (req_valid) begin
               if (!allowed)       state_nx = RESP;
               else if (req_write) state_nx = WRITE;
               else                state_nx = READ;
            end
         end
         WRITE: begin
            mem_we   = 1'b1;
            state_nx = RESP;
         end
         READ:    state_nx = CAPTURE;
         CAPTURE: state_nx = RESP;
         RESP: begin
            rsp_valid = 1'b1;
            if (rsp_ready) state_nx = IDLE;
         end
         default: state_nx = IDLE;
      endcase
   end

   // The FSM already sits in IDLE while reset is held, so gate ready explicitly.
   assign req_ready = idle_out && rst_n;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mem_addr  <= '0;
         mem_wdata <= '0;
         rsp_rdata <= '0;
         rsp_err   <= 1'b0;
      end else begin
         if (accept) begin
            if (allowed) begin
               mem_addr <= req_addr;
               if (req_write) mem_wdata <= req_wdata;
               rsp_err   <= 1'b0;
               rsp_rdata <= '0;
            end else begin
               rsp_err   <= 1'b1;
               rsp_rdata <= req_write ? 32'h0 : DENY_DATA;
            end
         end
         if (state == CAPTURE) rsp_rdata <= mem_rdata;
      end
   end

   // The request check reads the registered table, so a same-cycle cfg_we lands afterwards.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         locked <= 1'b0;
         for (int i = 0; i < REGIONS; i++) perm[i] <= 2'b00;
      end else begin
         if (cfg_lock) locked <= 1'b1;
         if (cfg_we && !locked) perm[cfg_region] <= cfg_perm;
      end
   end

`ifdef SECURE_STORAGE_AUDIT_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         deny_count     <= '0;
         last_deny_addr <= '0;
      end else if (accept && !allowed) begin
         if (deny_count != 16'hFFFF) deny_count <= deny_count + 16'd1;
         last_deny_addr <= req_addr;
      end
   end
`endif

endmodule

// File: tb/tb_secure_storage_initiator.sv
// Directed bench for secure_storage_initiator with a registered-read storage model.
module tb_secure_storage_initiator;

   logic        clk;
   logic        rst_n;
   logic        req_valid;
   logic        req_ready;
   logic        req_write;
   logic [7:0]  req_addr;
   logic [31:0] req_wdata;
   logic        rsp_valid;
   logic        rsp_ready;
   logic [31:0] rsp_rdata;
   logic        rsp_err;
   logic        cfg_we;
   logic [1:0]  cfg_region;
   logic [1:0]  cfg_perm;
   logic        cfg_lock;
   logic        locked;
   logic [7:0]  mem_addr;
   logic [31:0] mem_wdata;
   logic        mem_we;
   logic [31:0] mem_rdata;
`ifdef SECURE_STORAGE_AUDIT_EN
   logic [15:0] deny_count;
   logic [7:0]  last_deny_addr;
`endif

   int checks = 0;
   int errors = 0;
   int we_seen = 0;
   logic [31:0] tb_mem [256];

   secure_storage_initiator #(.REGIONS(4), .DENY_DATA(32'hDEAD_BEEF)) dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
      .req_addr(req_addr), .req_wdata(req_wdata),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
      .cfg_we(cfg_we), .cfg_region(cfg_region), .cfg_perm(cfg_perm), .cfg_lock(cfg_lock),
      .locked(locked),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_rdata(mem_rdata)
`ifdef SECURE_STORAGE_AUDIT_EN
      , .deny_count(deny_count), .last_deny_addr(last_deny_addr)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial for (int i = 0; i < 256; i++) tb_mem[i] = 32'hA500_0000 | i;

   // Storage model: synchronous write, registered read.
   always @(posedge clk) begin
      if (mem_we) begin
         tb_mem[mem_addr] <= mem_wdata;
         we_seen <= we_seen + 1;
      end
      mem_rdata <= tb_mem[mem_addr];
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_cfg(input logic [1:0] region, input logic [1:0] p, input logic we, input logic lk);
      cfg_we = we; cfg_region = region; cfg_perm = p; cfg_lock = lk;
      step();
      cfg_we = 1'b0; cfg_lock = 1'b0;
   endtask

   task automatic send_req(input logic wr, input logic [7:0] a, input logic [31:0] d,
                           output int lat, output logic [31:0] rd, output logic er);
      int n;
      n = 0;
      while (!req_ready && n < 20) begin step(); n++; end
      if (!req_ready) begin
         checks++; errors++;
         $display("FAIL req_ready_timeout addr=%h", a);
      end
      req_valid = 1'b1; req_write = wr; req_addr = a; req_wdata = d;
      step();
      req_valid = 1'b0;
      lat = 1;
      while (!rsp_valid && lat < 20) begin step(); lat++; end
      if (!rsp_valid) begin
         checks++; errors++;
         $display("FAIL rsp_valid_timeout addr=%h", a);
      end
      rd = rsp_rdata; er = rsp_err;
      rsp_ready = 1'b1;
      step();
      rsp_ready = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      step(); step();
      checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL reset_req_ready got=%b exp=0", req_ready); end
      checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid got=%b exp=0", rsp_valid); end
      checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL reset_mem_we got=%b exp=0", mem_we); end
      checks++; if (locked !== 1'b0) begin errors++; $display("FAIL reset_locked got=%b exp=0", locked); end
      checks++; if (mem_addr !== 8'h00 || mem_wdata !== 32'h0) begin errors++; $display("FAIL reset_mem_port got=%h/%h exp=00/0", mem_addr, mem_wdata); end
      checks++; if (rsp_rdata !== 32'h0 || rsp_err !== 1'b0) begin errors++; $display("FAIL reset_rsp got=%h/%b exp=0/0", rsp_rdata, rsp_err); end
`ifdef SECURE_STORAGE_AUDIT_EN
      checks++; if (deny_count !== 16'd0 || last_deny_addr !== 8'h00) begin errors++; $display("FAIL reset_audit got=%0d/%h exp=0/00", deny_count, last_deny_addr); end
`endif
      rst_n = 1'b1;
      step();
      checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL post_reset_req_ready got=%b exp=1", req_ready); end
   endtask

   task automatic test_default_deny();
      int lat; logic [31:0] rd; logic er;
      send_req(1'b0, 8'h10, 32'h0, lat, rd, er);
      checks++; if (er !== 1'b1) begin errors++; $display("FAIL deny_read_err got=%b exp=1", er); end
      checks++; if (rd !== 32'hDEAD_BEEF) begin errors++; $display("FAIL deny_read_data got=%h exp=deadbeef", rd); end
      checks++; if (lat != 1) begin errors++; $display("FAIL deny_latency got=%0d exp=1", lat); end
      send_req(1'b1, 8'h10, 32'hCAFE_0010, lat, rd, er);
      checks++; if (er !== 1'b1 || rd !== 32'h0) begin errors++; $display("FAIL deny_write got=%b/%h exp=1/0", er, rd); end
      checks++; if (we_seen != 0 || tb_mem[8'h10] !== 32'hA500_0010) begin errors++; $display("FAIL deny_no_mem_we got=%0d/%h exp=0/a5000010", we_seen, tb_mem[8'h10]); end
   endtask

   task automatic test_write_read();
      int lat; logic [31:0] rd; logic er;
      do_cfg(2'd0, 2'b11, 1'b1, 1'b0);
      send_req(1'b1, 8'h05, 32'h1234_5678, lat, rd, er);
      checks++; if (er !== 1'b0 || rd !== 32'h0) begin errors++; $display("FAIL write_rsp got=%b/%h exp=0/0", er, rd); end
      checks++; if (lat != 2) begin errors++; $display("FAIL write_latency got=%0d exp=2", lat); end
      checks++; if (tb_mem[8'h05] !== 32'h1234_5678 || we_seen != 1) begin errors++; $display("FAIL write_mem got=%h/%0d exp=12345678/1", tb_mem[8'h05], we_seen); end
      send_req(1'b0, 8'h05, 32'h0, lat, rd, er);
      checks++; if (er !== 1'b0 || rd !== 32'h1234_5678) begin errors++; $display("FAIL read_rsp got=%b/%h exp=0/12345678", er, rd); end
      checks++; if (lat != 3) begin errors++; $display("FAIL read_latency got=%0d exp=3", lat); end
   endtask

   task automatic test_read_only();
      int lat; logic [31:0] rd; logic er; int we0;
      do_cfg(2'd3, 2'b01, 1'b1, 1'b0);
      we0 = we_seen;
      send_req(1'b1, 8'hC0, 32'h5555_AAAA, lat, rd, er);
      checks++; if (er !== 1'b1 || we_seen != we0) begin errors++; $display("FAIL ro_write_denied got=%b/%0d exp=1/%0d", er, we_seen, we0); end
      send_req(1'b0, 8'hC0, 32'h0, lat, rd, er);
      checks++; if (er !== 1'b0 || rd !== 32'hA500_00C0) begin errors++; $display("FAIL ro_read got=%b/%h exp=0/a50000c0", er, rd); end
      send_req(1'b0, 8'hFF, 32'h0, lat, rd, er);
      checks++; if (er !== 1'b0 || rd !== 32'hA500_00FF) begin errors++; $display("FAIL top_addr_read got=%b/%h exp=0/a50000ff", er, rd); end
      send_req(1'b0, 8'hBF, 32'h0, lat, rd, er);
      checks++; if (er !== 1'b1) begin errors++; $display("FAIL region2_edge got=%b exp=1", er); end
   endtask

   task automatic test_cfg_same_cycle();
      int lat; logic [31:0] rd; logic er;
      req_valid = 1'b1; req_write = 1'b0; req_addr = 8'h80;
      cfg_we = 1'b1; cfg_region = 2'd2; cfg_perm = 2'b01;
      step();
      req_valid = 1'b0; cfg_we = 1'b0;
      checks++; if (rsp_valid !== 1'b1 || rsp_err !== 1'b1 || rsp_rdata !== 32'hDEAD_BEEF) begin
         errors++; $display("FAIL same_cycle_old_perm got=%b/%b/%h exp=1/1/deadbeef", rsp_valid, rsp_err, rsp_rdata);
      end
      rsp_ready = 1'b1; step(); rsp_ready = 1'b0;
      send_req(1'b0, 8'h80, 32'h0, lat, rd, er);
      checks++; if (er !== 1'b0 || rd !== 32'hA500_0080) begin errors++; $display("FAIL same_cycle_new_perm got=%b/%h exp=0/a5000080", er, rd); end
   endtask

   task automatic test_stall();
      int lat; int n; int we0;
      we0 = we_seen;
      req_valid = 1'b1; req_write = 1'b0; req_addr = 8'h05;
      step();
      n = 0;
      while (!rsp_valid && n < 20) begin step(); n++; end
      req_valid = 1'b1; req_write = 1'b1; req_addr = 8'h07; req_wdata = 32'hFFFF_0007;
      for (int i = 0; i < 5; i++) begin
         checks++;
         if (rsp_valid !== 1'b1 || rsp_rdata !== 32'h1234_5678 || req_ready !== 1'b0) begin
            errors++; $display("FAIL stall_hold cyc=%0d got=%b/%h/%b exp=1/12345678/0", i, rsp_valid, rsp_rdata, req_ready);
         end
         step();
      end
      req_valid = 1'b0;
      rsp_ready = 1'b1; step(); rsp_ready = 1'b0;
      checks++; if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin errors++; $display("FAIL stall_release got=%b/%b exp=0/1", rsp_valid, req_ready); end
      step(); step();
      checks++; if (we_seen != we0 || tb_mem[8'h07] !== 32'hA500_0007) begin errors++; $display("FAIL stall_no_accept got=%0d/%h exp=%0d/a5000007", we_seen, tb_mem[8'h07], we0); end
   endtask

   task automatic test_lock();
      int lat; logic [31:0] rd; logic er;
      do_cfg(2'd2, 2'b00, 1'b1, 1'b1);
      checks++; if (locked !== 1'b1) begin errors++; $display("FAIL lock_set got=%b exp=1", locked); end
      do_cfg(2'd1, 2'b11, 1'b1, 1'b0);
      send_req(1'b0, 8'h80, 32'h0, lat, rd, er);
      checks++; if (er !== 1'b1) begin errors++; $display("FAIL lock_same_cycle_cfg got=%b exp=1", er); end
      send_req(1'b0, 8'h40, 32'h0, lat, rd, er);
      checks++; if (er !== 1'b1 || rd !== 32'hDEAD_BEEF) begin errors++; $display("FAIL locked_cfg_ignored got=%b/%h exp=1/deadbeef", er, rd); end
      checks++; if (locked !== 1'b1) begin errors++; $display("FAIL lock_sticky got=%b exp=1", locked); end
   endtask

   task automatic test_reset_mid_txn();
      int n;
      req_valid = 1'b1; req_write = 1'b1; req_addr = 8'h06; req_wdata = 32'h0BAD_0006;
      step();
      req_valid = 1'b0;
      checks++; if (mem_we !== 1'b1) begin errors++; $display("FAIL write_state_we got=%b exp=1", mem_we); end
      rst_n = 1'b0;
      #1;
      checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL async_we_clear got=%b exp=0", mem_we); end
      #20;
      rst_n = 1'b1;
      step();
      checks++; if (tb_mem[8'h06] !== 32'hA500_0006 || locked !== 1'b0 || req_ready !== 1'b1) begin
         errors++; $display("FAIL write_abort got=%h/%b/%b exp=a5000006/0/1", tb_mem[8'h06], locked, req_ready);
      end
      do_cfg(2'd0, 2'b11, 1'b1, 1'b0);
      req_valid = 1'b1; req_write = 1'b0; req_addr = 8'h05;
      step();
      req_valid = 1'b0;
      step();
      rst_n = 1'b0;
      n = 0;
      for (int i = 0; i < 3; i++) begin
         #1;
         if (rsp_valid !== 1'b0) n++;
         step();
      end
      checks++; if (n != 0) begin errors++; $display("FAIL capture_abort_rsp got=%0d exp=0", n); end
      rst_n = 1'b1;
      step();
      checks++; if (req_ready !== 1'b1 || locked !== 1'b0 || rsp_valid !== 1'b0 || rsp_rdata !== 32'h0) begin
         errors++; $display("FAIL capture_abort_state got=%b/%b/%b/%h exp=1/0/0/0", req_ready, locked, rsp_valid, rsp_rdata);
      end
   endtask

   task automatic test_audit();
      int lat; logic [31:0] rd; logic er;
      send_req(1'b0, 8'h05, 32'h0, lat, rd, er);
      checks++; if (er !== 1'b1) begin errors++; $display("FAIL perm0_cleared got=%b exp=1", er); end
      send_req(1'b1, 8'h7F, 32'h1, lat, rd, er);
      checks++; if (er !== 1'b1) begin errors++; $display("FAIL perm1_cleared got=%b exp=1", er); end
      send_req(1'b0, 8'hC3, 32'h0, lat, rd, er);
      checks++; if (er !== 1'b1) begin errors++; $display("FAIL perm3_cleared got=%b exp=1", er); end
`ifdef SECURE_STORAGE_AUDIT_EN
      checks++; if (deny_count !== 16'd3 || last_deny_addr !== 8'hC3) begin
         errors++; $display("FAIL audit got=%0d/%h exp=3/c3", deny_count, last_deny_addr);
      end
`endif
   endtask

   initial begin
      rst_n = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0;
      rsp_ready = 1'b0; cfg_we = 1'b0; cfg_region = '0; cfg_perm = '0; cfg_lock = 1'b0;
      test_reset();
      test_default_deny();
      test_write_read();
      test_read_only();
      test_cfg_same_cycle();
      test_stall();
      test_lock();
      test_reset_mid_txn();
      test_audit();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
